// File: rtl/pla_eval.sv
// Programmable AND/OR plane evaluator behind a two-stage valid/ready pipeline.
// Term and OR tables are rewritten through the config port only while the pipe is empty.
module pla_eval #(
  parameter int N_IN   = 5,
  parameter int N_OUT  = 5,
  parameter int N_TERM = 6,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [N_IN-1:0]   cfg_care,
  input  logic [N_IN-1:0]   cfg_val,
  input  logic [N_TERM-1:0] cfg_omask,
  output logic              cfg_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data,
  output logic [N_TERM-1:0] out_terms,
  output logic [15:0]       eval_count
);

  localparam logic [AW:0] TERM_LIMIT = (AW+1)'(N_TERM);
  localparam logic [AW:0] OUT_LIMIT  = (AW+1)'(N_OUT);

  logic [N_IN-1:0]   care_q  [N_TERM];
  logic [N_IN-1:0]   care_d  [N_TERM];
  logic [N_IN-1:0]   val_q   [N_TERM];
  logic [N_IN-1:0]   val_d   [N_TERM];
  logic [N_TERM-1:0] omask_q [N_OUT];
  logic [N_TERM-1:0] omask_d [N_OUT];

  logic              s1_valid_q, s1_valid_d;
  logic [N_TERM-1:0] s1_match_q, s1_match_d;
  logic              s2_valid_q, s2_valid_d;
  logic [N_OUT-1:0]  out_data_q, out_data_d;
  logic [N_TERM-1:0] out_terms_q, out_terms_d;
  logic [15:0]       eval_count_q, eval_count_d;

  logic              adv;
  logic              in_fire;
  logic              cfg_fire;
  logic              term_addr_ok;
  logic              out_addr_ok;
  logic [N_TERM-1:0] match;
  logic [N_OUT-1:0]  or_plane;

  assign adv          = !s2_valid_q || out_ready;
  assign in_ready     = adv && !cfg_we;
  assign in_fire      = in_valid && in_ready;
  assign cfg_ready    = !s1_valid_q && !s2_valid_q;
  assign cfg_fire     = cfg_we && cfg_ready;
  assign term_addr_ok = {1'b0, cfg_addr} < TERM_LIMIT;
  assign out_addr_ok  = {1'b0, cfg_addr} < OUT_LIMIT;

  assign out_valid  = s2_valid_q;
  assign out_data   = out_data_q;
  assign out_terms  = out_terms_q;
  assign eval_count = eval_count_q;

  // AND plane: uncared variables never disqualify a term.
  always_comb begin
    match = '0;
    for (int t = 0; t < N_TERM; t++) begin
      match[t] = ((in_data ^ val_q[t]) & care_q[t]) == '0;
    end
  end

  always_comb begin
    or_plane = '0;
    for (int o = 0; o < N_OUT; o++) begin
      or_plane[o] = |(s1_match_q & omask_q[o]);
    end
  end

  // Writes only land when both stages are empty, so no in-flight lookup sees a mixed entry.
  always_comb begin
    care_d  = care_q;
    val_d   = val_q;
    omask_d = omask_q;
    if (cfg_fire && !cfg_sel && term_addr_ok) begin
      for (int t = 0; t < N_TERM; t++) begin
        if (cfg_addr == AW'(t)) begin
          care_d[t] = cfg_care;
          val_d[t]  = cfg_val;
        end
      end
    end
    if (cfg_fire && cfg_sel && out_addr_ok) begin
      for (int o = 0; o < N_OUT; o++) begin
        if (cfg_addr == AW'(o)) begin
          omask_d[o] = cfg_omask;
        end
      end
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_match_d   = s1_match_q;
    s2_valid_d   = s2_valid_q;
    out_data_d   = out_data_q;
    out_terms_d  = out_terms_q;
    eval_count_d = eval_count_q;
    if (adv) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_match_d = match;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d  = or_plane;
        out_terms_d = s1_match_q;
      end
    end
    if (in_fire && (eval_count_q != 16'hFFFF)) begin
      eval_count_d = eval_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      care_q       <= '{default: '0};
      val_q        <= '{default: '0};
      omask_q      <= '{default: '0};
      s1_valid_q   <= 1'b0;
      s1_match_q   <= '0;
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_terms_q  <= '0;
      eval_count_q <= '0;
    end else begin
      care_q       <= care_d;
      val_q        <= val_d;
      omask_q      <= omask_d;
      s1_valid_q   <= s1_valid_d;
      s1_match_q   <= s1_match_d;
      s2_valid_q   <= s2_valid_d;
      out_data_q   <= out_data_d;
      out_terms_q  <= out_terms_d;
      eval_count_q <= eval_count_d;
    end
  end

endmodule

// File: tb/tb_pla_eval.sv
// Directed bench for pla_eval: hand-computed vector table plus scoreboarded streams
// covering stalls, config priority, config during a full pipe and mid-flight reset.
module tb_pla_eval;

  localparam int N_IN   = 5;
  localparam int N_OUT  = 5;
  localparam int N_TERM = 6;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic              cfg_sel = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [N_IN-1:0]   cfg_care = '0;
  logic [N_IN-1:0]   cfg_val = '0;
  logic [N_TERM-1:0] cfg_omask = '0;
  logic              cfg_ready;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N_IN-1:0]   in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [N_OUT-1:0]  out_data;
  logic [N_TERM-1:0] out_terms;
  logic [15:0]       eval_count;

  always #5 clk = ~clk;

  pla_eval #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .N_TERM(N_TERM),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_care  (cfg_care),
    .cfg_val   (cfg_val),
    .cfg_omask (cfg_omask),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_terms (out_terms),
    .eval_count(eval_count)
  );

  typedef struct packed {
    logic [N_TERM-1:0] terms;
    logic [N_OUT-1:0]  data;
  } res_t;

  typedef struct {
    logic [N_IN-1:0]   in_vec;
    logic [N_TERM-1:0] terms;
    logic [N_OUT-1:0]  data;
  } vec_t;

  logic [N_IN-1:0]   m_care  [N_TERM];
  logic [N_IN-1:0]   m_val   [N_TERM];
  logic [N_TERM-1:0] m_omask [N_OUT];
  res_t              exp_q[$];
  vec_t              vecs[8];

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int exp_eval = 0;
  bit cfg_written = 1'b0;
  bit in_fired = 1'b0;

  // Reference evaluation done variable by variable rather than as a masked compare.
  function automatic res_t model(input logic [N_IN-1:0] x);
    res_t r;
    bit   hit;
    r = '0;
    for (int t = 0; t < N_TERM; t++) begin
      hit = 1'b1;
      for (int i = 0; i < N_IN; i++) begin
        if (m_care[t][i] && (x[i] != m_val[t][i])) hit = 1'b0;
      end
      r.terms[t] = hit;
    end
    for (int o = 0; o < N_OUT; o++) begin
      for (int t = 0; t < N_TERM; t++) begin
        if (r.terms[t] && m_omask[o][t]) r.data[o] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int t = 0; t < N_TERM; t++) begin
      m_care[t] = '0;
      m_val[t]  = '0;
    end
    for (int o = 0; o < N_OUT; o++) m_omask[o] = '0;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock: sample handshakes shortly after inputs settle, then advance past the edge.
  task automatic step_cycle();
    res_t e;
    #2;
    in_fired = 1'b0;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_data));
      if (exp_eval < 65535) exp_eval++;
      in_fired = 1'b1;
    end
    if (cfg_we && cfg_ready) begin
      cfg_written = 1'b1;
      if (!cfg_sel && (int'(cfg_addr) < N_TERM)) begin
        m_care[cfg_addr] = cfg_care;
        m_val[cfg_addr]  = cfg_val;
      end
      if (cfg_sel && (int'(cfg_addr) < N_OUT)) m_omask[cfg_addr] = cfg_omask;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got output 0x%0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        check_output("sb_data", 32'(out_data), 32'(e.data));
        check_output("sb_terms", 32'(out_terms), 32'(e.terms));
        out_count++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [AW-1:0] addr, input logic [N_IN-1:0] care,
                           input logic [N_IN-1:0] val, input logic [N_TERM-1:0] omask);
    int n;
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr;
    cfg_care = care; cfg_val = val; cfg_omask = omask;
    cfg_written = 1'b0;
    n = 0;
    while (!cfg_written && n < 10) begin
      step_cycle();
      n++;
    end
    cfg_we = 1'b0;
    check_output("cfg_write_done", 32'(cfg_written), 32'd1);
  endtask

  // Single transaction with exact latency checks against hand-computed results.
  task automatic apply_stimulus(input vec_t v);
    in_valid = 1'b1;
    in_data  = v.in_vec;
    #1;
    check_output("vec_in_ready", 32'(in_ready), 32'd1);
    step_cycle();
    in_valid = 1'b0;
    check_output("vec_lat_s1", 32'(out_valid), 32'd0);
    step_cycle();
    check_output("vec_lat_s2", 32'(out_valid), 32'd1);
    check_output("vec_terms", 32'(out_terms), 32'(v.terms));
    check_output("vec_data", 32'(out_data), 32'(v.data));
    step_cycle();
    check_output("vec_consumed", 32'(out_valid), 32'd0);
  endtask

  task automatic run_stream(input int n, input int base, input int stall_start, input int stall_len,
                            output int cyc);
    int sent;
    sent = 0;
    cyc  = 0;
    while ((sent < n || exp_q.size() != 0) && cyc < n + stall_len + 20) begin
      out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      in_valid  = (sent < n);
      in_data   = N_IN'(base + sent);
      #1;
      if (!out_ready && out_valid) begin
        check_output("stall_in_ready", 32'(in_ready), 32'd0);
        if (exp_q.size() != 0) check_output("stall_hold", 32'(out_data), 32'(exp_q[0].data));
      end
      step_cycle();
      if (in_fired) sent++;
      cyc++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check_output("stream_sent", 32'(sent), 32'(n));
    check_output("stream_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    int eval_base;
    int out_base;
    vec_t v;

    vecs[0] = '{5'b00000, 6'b111110, 5'b00011};
    vecs[1] = '{5'b10000, 6'b111111, 5'b00011};
    vecs[2] = '{5'b00100, 6'b011010, 5'b00000};
    vecs[3] = '{5'b00001, 6'b011110, 5'b00010};
    vecs[4] = '{5'b00010, 6'b111010, 5'b00011};
    vecs[5] = '{5'b11111, 6'b011010, 5'b00000};
    vecs[6] = '{5'b10011, 6'b011011, 5'b00000};
    vecs[7] = '{5'b11000, 6'b111110, 5'b00011};
    clear_model();

    #3;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_out_terms", 32'(out_terms), 32'd0);
    check_output("rst_eval_count", 32'(eval_count), 32'd0);
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    #1;
    check_output("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_output("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;

    // Cleared tables: every term matches, every output is zero.
    v = '{5'b10101, 6'b111111, 5'b00000};
    apply_stimulus(v);

    cfg_write(1'b0, 3'd0, 5'b11000, 5'b10000, '0);
    cfg_write(1'b0, 3'd2, 5'b00110, 5'b00000, '0);
    cfg_write(1'b0, 3'd5, 5'b00101, 5'b00000, '0);
    cfg_write(1'b1, 3'd0, '0, '0, 6'b100000);
    cfg_write(1'b1, 3'd1, '0, '0, 6'b100100);
    foreach (vecs[k]) apply_stimulus(vecs[k]);

    eval_base = exp_eval;
    out_base  = out_count;
    run_stream(32, 0, 0, 0, cyc);
    check_output("stream_cycles", 32'(cyc), 32'd34);
    check_output("stream_outputs", 32'(out_count - out_base), 32'd32);
    check_output("stream_eval_count", 32'(eval_count), 32'(eval_base + 32));

    out_base = out_count;
    run_stream(16, 7, 6, 5, cyc);
    check_output("stall_outputs", 32'(out_count - out_base), 32'd16);
    check_output("stall_eval_count", 32'(eval_count), 32'(exp_eval));

    // Config takes priority over a simultaneous input on an empty pipe.
    cfg_write(1'b1, 3'd2, '0, '0, 6'b000010);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd1;
    cfg_care = 5'b00001; cfg_val = 5'b00001;
    in_valid = 1'b1; in_data = 5'b00000;
    cfg_written = 1'b0;
    #1;
    check_output("prio_in_ready", 32'(in_ready), 32'd0);
    check_output("prio_cfg_ready", 32'(cfg_ready), 32'd1);
    step_cycle();
    check_output("prio_written", 32'(cfg_written), 32'd1);
    cfg_we = 1'b0;
    #1;
    check_output("prio_in_ready_after", 32'(in_ready), 32'd1);
    step_cycle();
    in_valid = 1'b0;
    step_cycle();
    check_output("prio_out_valid", 32'(out_valid), 32'd1);
    check_output("prio_terms", 32'(out_terms), 32'b111100);
    check_output("prio_data", 32'(out_data), 32'b00011);
    step_cycle();

    // Config request against a full, stalled pipe; out-of-range addresses are ignored.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5'b00001;
    step_cycle();
    in_data = 5'b10000;
    step_cycle();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd7;
    cfg_care = 5'b11111; cfg_val = 5'b11111;
    cfg_written = 1'b0;
    repeat (3) begin
      #1;
      check_output("full_cfg_ready", 32'(cfg_ready), 32'd0);
      check_output("full_in_ready", 32'(in_ready), 32'd0);
      step_cycle();
    end
    check_output("full_no_write", 32'(cfg_written), 32'd0);
    out_ready = 1'b1;
    n = 0;
    while (!cfg_written && n < 8) begin
      step_cycle();
      n++;
    end
    cfg_we = 1'b0;
    check_output("drain_write", 32'(cfg_written), 32'd1);
    check_output("drain_cycles", 32'(n), 32'd3);
    cfg_write(1'b1, 3'd5, '0, '0, 6'b111111);
    v = '{5'b00001, 6'b011110, 5'b00110};
    apply_stimulus(v);
    v = '{5'b00000, 6'b111100, 5'b00011};
    apply_stimulus(v);

    // Reset with two transactions in flight.
    in_valid = 1'b1; in_data = 5'b00000;
    step_cycle();
    in_data = 5'b10000;
    step_cycle();
    in_valid = 1'b0;
    check_output("inflight_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_out_data", 32'(out_data), 32'd0);
    check_output("midrst_out_terms", 32'(out_terms), 32'd0);
    check_output("midrst_eval_count", 32'(eval_count), 32'd0);
    exp_q.delete();
    clear_model();
    exp_eval = 0;
    @(posedge clk);
    #1;
    check_output("midrst_hold_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check_output("midrst_in_ready", 32'(in_ready), 32'd1);
    check_output("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    check_output("midrst_no_output", 32'(out_valid), 32'd0);
    v = '{5'b00000, 6'b111111, 5'b00000};
    apply_stimulus(v);
    check_output("midrst_eval_after", 32'(eval_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pla_eval.md
PLA_EVAL -- requirements
Module: pla_eval

Interface
REQ-001 Parameter N_IN, default 5: number of input variables.
REQ-002 Parameter N_OUT, default 5: number of outputs.
REQ-003 Parameter N_TERM, default 6: number of product terms.
REQ-004 Parameter AW, default 3: config address width; SHALL satisfy 2**AW >= max(N_TERM, N_OUT).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 cfg_we  in  1  config write request.
REQ-008 cfg_sel  in  1  target table: 0 = term table, 1 = output OR table.
REQ-009 cfg_addr  in  AW  term index (cfg_sel=0) or output index (cfg_sel=1).
REQ-010 cfg_care  in  N_IN  term care mask; bit=1 means the variable is tested.
REQ-011 cfg_val  in  N_IN  term required values, for cared bits only.
REQ-012 cfg_omask  in  N_TERM  output OR mask; bit t=1 means term t feeds this output.
REQ-013 cfg_ready  out  1  config write accepted this cycle.
REQ-014 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-015 in_data  in  N_IN  input vector; bit i = variable x_i.
REQ-016 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-017 out_data  out  N_OUT  evaluated outputs.
REQ-018 out_terms  out  N_TERM  term match vector for the same transaction.
REQ-019 eval_count  out  16  number of transactions accepted at the input.

Function
REQ-020 Term t SHALL match iff ((in_data ^ val[t]) & care[t]) == 0; a term with care = 0 always matches.
REQ-021 out_data[o] SHALL equal the OR over all t of (match[t] & omask[o][t]).
REQ-022 Pipeline SHALL have two stages: S1 registers the match vector; S2 registers out_data and out_terms.
REQ-023 Latency SHALL be 2 cycles from input acceptance to out_valid, with no stalls.
REQ-024 Throughput SHALL be 1 transaction per cycle while out_ready=1.
REQ-025 Advance enable: adv = !out_valid || out_ready; in_ready = adv && !cfg_we.
REQ-026 When adv=0, S1 and S2 SHALL hold.
REQ-027 out_data and out_terms SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 A bubble in S1 SHALL propagate; out_valid SHALL fall only when S2 is consumed and S1 is empty.
REQ-029 Input transfer occurs on in_valid && in_ready; output transfer occurs on out_valid && out_ready.
REQ-030 cfg_ready SHALL be 1 iff S1 and S2 are both empty.
REQ-031 A write SHALL occur on cfg_we && cfg_ready and SHALL take effect at the next edge.
REQ-032 Table reads SHALL never see a partially updated entry.
REQ-033 cfg_we SHALL block input acceptance (in_ready=0) even when the pipeline is empty; config has priority over data.
REQ-034 A cfg_addr >= N_TERM (cfg_sel=0) or >= N_OUT (cfg_sel=1) SHALL be ignored, with no table change; cfg_ready still follows REQ-030.
REQ-035 eval_count SHALL increment on each input transfer and saturate at 0xFFFF without wrapping.

Reset
REQ-036 While rst_n=0, S1 and S2 valids SHALL be cleared, out_valid=0, out_data=0, out_terms=0, and eval_count=0.
REQ-037 Reset SHALL clear all care, val and omask entries to 0: every term matches and every output is 0.
REQ-038 A transaction in flight at reset SHALL be discarded, with no output transfer.
REQ-039 After rst_n deasserts, in_ready=1 and cfg_ready=1 on the first cycle.

Verification
REQ-040 Defaults; write terms t0 care=11000 val=10000, t2 care=00110 val=00000, t5 care=00101 val=00000; omask o0=100000, o1=100100; drive in=00000 -> out_terms bits 2 and 5 set, out_data=00011, 2 cycles later.
REQ-041 Same table; stream all 32 inputs back-to-back with out_ready=1 -> 32 outputs on consecutive cycles matching the golden SOP, eval_count=32.
REQ-042 out_ready=0 for 5 cycles mid-stream -> out_data held and in_ready=0 after the pipe fills; no loss or duplication after release.
REQ-043 cfg_we held high while in_valid=1 on an empty pipe -> write occurs, in_ready=0, then data is accepted the next cycle with the new table.
REQ-044 cfg_we issued with the pipeline full -> cfg_ready=0 until drained; cfg_addr=7 with cfg_sel=0 leaves the table unchanged.
REQ-045 rst_n pulsed low with 2 transactions in flight -> out_valid=0 immediately, no output transfer, tables cleared, eval_count=0.
